// File: rtl/bist_reg_driver_pkg.sv
// ============================================================================
// Module      : bist_reg_driver_pkg
// Description : Shared constants and types for the BIST register-chain driver:
//               sequencer state encoding and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bist_reg_driver_pkg;

  // Default BIST register width; the top derives N = width - 1 from it
  localparam int c_def_width = 16;

  // Width of the half-period counter (HALF is legal up to 255)
  localparam int c_half_cnt_w = 8;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bist_reg_driver_clk_pulse_gen.sv
// ============================================================================
// Module      : bist_clk_pulse_gen
// Description : Generates registered, glitch-free clock pulses (HALF cycles
//               low, then HALF cycles high) back to back while i_trig is
//               high. Flags the last low cycle (data sample point) and the
//               last high cycle (pulse complete).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_clk_pulse_gen
  import bist_reg_driver_pkg::*;
#(
  parameter int HALF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_trig,
  output logic o_clk,
  output logic o_last_low,
  output logic o_pulse_done
);

  localparam logic [c_half_cnt_w-1:0] c_reload = c_half_cnt_w'(HALF - 1);

  logic                    r_high;
  logic [c_half_cnt_w-1:0] r_cnt;
  logic                    w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Half-period counter and phase; idles low with a full reload so the first
  // pulse after a trigger always starts with a complete low half
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high <= 1'b0;
      r_cnt  <= c_reload;
    end else if (!i_trig) begin
      r_high <= 1'b0;
      r_cnt  <= c_reload;
    end else if (w_cnt_zero) begin
      r_high <= ~r_high;
      r_cnt  <= c_reload;
    end else begin
      r_cnt  <= r_cnt - c_half_cnt_w'(1);
    end
  end

  // The generated clock is the phase flop itself, so it can never glitch
  assign o_clk        = r_high;
  assign o_last_low   = i_trig & ~r_high & w_cnt_zero;
  assign o_pulse_done = i_trig &  r_high & w_cnt_zero;

endmodule

`default_nettype wire

// File: rtl/bist_reg_driver.sv
// ============================================================================
// Module      : bist_reg_driver
// Description : Initiator-side sequencer for the BIST scan register chain.
//               Per request runs one DR scan (capture, shift N+1 bits LSB
//               first, update) and collects the chain's serial output into a
//               parallel read word. N must be at least 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_reg_driver
  import bist_reg_driver_pkg::*;
#(
  parameter int N    = c_def_width - 1,
  parameter int HALF = 1
) (
  input  logic       Sys_clk,
  input  logic       Test_Log_Res,
  input  logic       Start,
  input  logic [N:0] Wr_data,
  output logic [N:0] Rd_data,
  output logic       Busy,
  output logic       Done,
  output logic       Shift_DR,
  output logic       Shift_in,
  input  logic       Shift_out,
  output logic       BIST_Sh_t_clk,
  output logic       BIST_Com_t_clk
);

  localparam int              c_bw       = (N > 0) ? $clog2(N + 1) : 1;
  localparam logic [c_bw-1:0] c_last_bit = c_bw'(N);

  state_t          r_state;
  logic [N:0]      r_sr;
  logic [N:0]      r_rd;
  logic [N:0]      w_sr_next;
  logic [c_bw-1:0] r_bit;
  logic            r_busy;
  logic            r_done;
  logic            r_shift_dr;
  logic            r_shift_in;

  logic            w_sh_trig;
  logic            w_com_trig;
  logic            w_sh_last_low;
  logic            w_sh_done;
  logic            w_com_done;
  logic            w_com_last_low_unused;

  // The shift clock runs continuously through capture and all shift bits;
  // the update clock only during UPDATE
  assign w_sh_trig  = (r_state == ST_CAPTURE) || (r_state == ST_SHIFT);
  assign w_com_trig = (r_state == ST_UPDATE);
  assign w_sr_next  = r_sr >> 1;

  bist_clk_pulse_gen #(.HALF(HALF)) u_sh_clk (
    .clk          (Sys_clk),
    .rst          (Test_Log_Res),
    .i_trig       (w_sh_trig),
    .o_clk        (BIST_Sh_t_clk),
    .o_last_low   (w_sh_last_low),
    .o_pulse_done (w_sh_done)
  );

  bist_clk_pulse_gen #(.HALF(HALF)) u_com_clk (
    .clk          (Sys_clk),
    .rst          (Test_Log_Res),
    .i_trig       (w_com_trig),
    .o_clk        (BIST_Com_t_clk),
    .o_last_low   (w_com_last_low_unused),
    .o_pulse_done (w_com_done)
  );

  // Scan sequencer; Shift_in/Shift_DR only change on a pulse_done edge, i.e.
  // exactly when the shift clock returns low
  always_ff @(posedge Sys_clk or posedge Test_Log_Res) begin
    if (Test_Log_Res) begin
      r_state    <= ST_IDLE;
      r_sr       <= '0;
      r_rd       <= '0;
      r_bit      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shift_dr <= 1'b0;
      r_shift_in <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_sr    <= Wr_data;
            r_bit   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_sh_done) begin
            r_shift_dr <= 1'b1;
            r_shift_in <= r_sr[0];
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Bit k lands in Rd_data[k] after N+1 right shifts
          if (w_sh_last_low) begin
            r_rd <= {Shift_out, r_rd[N:1]};
          end
          if (w_sh_done) begin
            if (r_bit == c_last_bit) begin
              r_shift_dr <= 1'b0;
              r_shift_in <= 1'b0;
              r_state    <= ST_UPDATE;
            end else begin
              r_bit      <= r_bit + c_bw'(1);
              r_sr       <= w_sr_next;
              r_shift_in <= w_sr_next[0];
            end
          end
        end
        ST_UPDATE: begin
          if (w_com_done) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Rd_data  = r_rd;
  assign Busy     = r_busy;
  assign Done     = r_done;
  assign Shift_DR = r_shift_dr;
  assign Shift_in = r_shift_in;

endmodule

`default_nettype wire

// File: doc/bist_reg_driver.md
Name: bist_reg_driver

Overview:
- Initiator-side sequencer for the BIST scan register chain.
- Takes a parallel write word and produces the control signals that the chain consumes:
  - Shift_DR
  - the serial Shift_in data
  - the BIST_Sh_t_clk shift/capture clock
  - the BIST_Com_t_clk update clock
- Collects the chain's serial Shift_out into a parallel read word.
- Runs one complete DR scan per request, in three phases: capture, shift, update.
- Sits between the test controller logic and the BIST register chain.

Parameters:
- N, 15, register width minus one; the chain length is N+1 bits.
- HALF, 1, Sys_clk cycles per half-period of each generated clock; legal range 1..255.

Ports:
- Sys_clk  in  1  system clock; all logic is on the rising edge.
- Test_Log_Res  in  1  asynchronous, active-high reset.
- Start  in  1  scan request; sampled only while in IDLE.
- Wr_data  in  N+1  word to shift into the chain; registered when Start is accepted.
- Rd_data  out  N+1  word captured from the chain; valid from the Done pulse until the next accepted Start.
- Busy  out  1  high from the cycle after Start is accepted until the end of the DONE cycle.
- Done  out  1  one-cycle pulse when a scan completes.
- Shift_DR  out  1  drives the chain's Shift_DR; high only in SHIFT.
- Shift_in  out  1  serial data to the chain's MSB cell.
- Shift_out  in  1  serial data from the chain's LSB cell.
- BIST_Sh_t_clk  out  1  generated shift/capture clock; registered output, glitch-free.
- BIST_Com_t_clk  out  1  generated update clock; registered output, glitch-free.

Behaviour:
- Reset (asynchronous, any time, including mid-scan):
  - state goes to IDLE; all outputs go to 0; Rd_data goes to 0; counters clear.
  - No partial clock pulse may be emitted once reset is asserted.
- States: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- IDLE:
  - Start=1 latches Wr_data into an internal shift register and moves to CAPTURE.
  - Start is ignored in every other state, and no request is queued.
- Generated clock pulse:
  - HALF cycles with the clock low, then HALF cycles with it high.
  - A half-period counter counts HALF-1 down to 0.
- CAPTURE:
  - Shift_DR=0; one BIST_Sh_t_clk pulse, which makes the chain load its Par_in.
  - Then go to SHIFT.
- SHIFT:
  - Shift_DR=1; a bit counter k runs 0..N.
  - For each k:
    - In the low half, Shift_in = Wr_data[k] (LSB first).
    - On the last low cycle, sample Shift_out into Rd_data[k].
    - Then the high half.
  - Shift_in changes only while BIST_Sh_t_clk is low.
  - After k=N completes: Shift_DR=0 and go to UPDATE.
  - The chain then holds Wr_data with bit i in cell i.
- UPDATE:
  - Shift_DR=0, Shift_in=0; one BIST_Com_t_clk pulse.
  - Then go to DONE.
- DONE:
  - Done=1 for exactly one cycle; Rd_data is stable; return to IDLE.
- Latency:
  - Start accepted at cycle 0.
  - Done is asserted in cycle 2*HALF*(N+3)+1.
  - For N=15, HALF=1 this is cycle 37.
- BIST_Sh_t_clk and BIST_Com_t_clk are never high in the same cycle.
- Boundary conditions:
  - Start held high continuously: one scan runs per IDLE visit, so back-to-back scans are separated by one IDLE cycle.
  - Start asserted during DONE is ignored.
  - Wr_data changes after acceptance have no effect on the scan in progress.

Decomposition:
- Shared package holds:
  - state encoding constants (3-bit: IDLE=0, CAPTURE=1, SHIFT=2, UPDATE=3, DONE=4)
  - the default width constant 16.
- One sub-module, bist_clk_pulse_gen:
  - takes a trigger and HALF
  - produces one registered low/high clock pulse, a last_low strobe (sample point) and a pulse_done strobe
  - one instance for BIST_Sh_t_clk, one for BIST_Com_t_clk.

Test Plan:
- Reset mid-SHIFT:
  - Stimulus: assert Test_Log_Res at k=5.
  - Required: all outputs and Rd_data are 0 in the same cycle (asynchronous); Busy=0; after release, a new Start runs a full scan.
- Loopback against a behavioural 16-bit chain model with Par_in=16'hA5C3, Wr_data=16'h1234, HALF=1:
  - Rd_data=16'hA5C3.
  - The model's cells hold 16'h1234 at UPDATE.
  - Done occurs at cycle 37.
  - Exactly 17 BIST_Sh_t_clk pulses and 1 BIST_Com_t_clk pulse.
- HALF=3, Wr_data=16'hFFFF, Par_in=16'h0001:
  - Every clock high and low period is 3 cycles.
  - Rd_data=16'h0001.
  - Done occurs at cycle 109.
- Start held high for 100 cycles:
  - Scans repeat with Busy low for exactly one cycle between them.
  - Wr_data changed mid-scan does not alter the current shifted bits.
- Protocol checker across all runs:
  - Shift_in never toggles while BIST_Sh_t_clk=1.
  - Shift_DR=1 only during SHIFT.
  - The two generated clocks are never high together.
  - Start while Busy=1 produces no effect.
